piso_serializer: RTL

//   Parallel-in serial-out transmitter: accepts a WIDTH-bit word on a valid/ready

---
 rtl/piso_pkg.sv | 20 ++
 rtl/piso_bit_counter.sv | 42 ++++
 rtl/piso_serializer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piso_pkg
// Description : Shared state encoding and counter width helper for the
//               parallel-in serial-out serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : piso_bit_counter
// Description : Bit position counter for one serial frame (0..WIDTH-1) with
//               first/last bit decodes.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic load,
    input  logic inc,
    output logic is_first,
    output logic is_last
);

    localparam int                 c_cnt_w = cnt_w(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;

    // load wins over inc so a back-to-back reload restarts at bit 0
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + c_one;
        end
    end

    assign is_first = (r_cnt == '0);
    assign is_last  = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in serial-out transmitter with valid/ready on both
//               sides and frame start/end flags; supports back-to-back frames.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    piso_state_t      r_state;
    piso_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shifted;
    logic             w_send_bit;
    logic             w_busy;
    logic             w_first;
    logic             w_last;
    logic             w_accept;
    logic             w_cnt_load;
    logic             w_cnt_inc;
    logic             w_word_load;

    generate
        if (LSB_FIRST == 0) begin : g_msb_first
            assign w_shifted  = {r_shreg[WIDTH-2:0], 1'b0};
            assign w_send_bit = r_shreg[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted  = {1'b0, r_shreg[WIDTH-1:1]};
            assign w_send_bit = r_shreg[0];
        end
    endgenerate

    piso_bit_counter #(
        .WIDTH    (WIDTH)
    ) u_bit_counter (
        .clk      (clk),
        .clear    (clear),
        .load     (w_cnt_load),
        .inc      (w_cnt_inc),
        .is_first (w_first),
        .is_last  (w_last)
    );

    assign w_busy      = (r_state == SHIFT);
    assign frame_end   = w_busy & w_last;
    assign frame_start = w_busy & w_first;
    assign sout_valid  = w_busy;
    assign busy        = w_busy;
    assign sout        = w_busy & w_send_bit;
    // ready never looks at load_valid, so no loop through the source
    assign load_ready  = (r_state == IDLE) | (frame_end & sout_ready);
    assign w_accept    = load_valid & load_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_inc   = 1'b0;
        w_word_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_word_load = 1'b1;
                    w_cnt_load  = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (sout_ready) begin
                    if (!w_last) begin
                        w_cnt_inc = 1'b1;
                    end else if (w_accept) begin
                        w_word_load = 1'b1;
                        w_cnt_load  = 1'b1;
                    end else begin
                        w_cnt_load  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_shreg <= '0;
        end else if (w_word_load) begin
            r_shreg <= din;
        end else if (w_cnt_inc) begin
            r_shreg <= w_shifted;
        end
    end

endmodule
`default_nettype wire
